// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/funct constants, control encodings, stage bundle layouts and Tnew/Tuse values
// for the pipeline hazard controller and its decoder.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;

    localparam logic [2:0] NPC_SEQ = 3'd0, NPC_BEQ = 3'd1, NPC_JR = 3'd2, NPC_J = 3'd3;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_OR = 4'd2, ALU_LUI = 4'd3;
    localparam logic [2:0] DM_W = 3'd0, DM_B = 3'd1, DM_H = 3'd2;
    localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC8 = 2'd2;
    localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1;
    localparam logic [2:0] CMP_EQ = 3'd0;
    localparam logic [1:0] FWD_GRF = 2'd0, FWD_M = 2'd1, FWD_W = 2'd2, FWD_E = 2'd3;

    localparam logic [1:0] TNEW_LOAD = 2'd2, TNEW_ALU = 2'd1, TNEW_LINK = 2'd0;
    localparam logic [1:0] TUSE_BR = 2'd0, TUSE_ALU = 2'd1, TUSE_ST = 2'd2;

    typedef struct packed {
        logic [2:0] npc_op;
        logic [1:0] ext_op;
        logic [2:0] cmp_op;
    } dctl_t;

    // rs/rt are zero when the instruction does not read that operand
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alub_sel;
        logic       dm_we;
        logic [2:0] dm_op;
        logic       reg_we;
        logic [1:0] wd_sel;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] tnew;
    } bndl_t;

    typedef struct packed {
        logic       dm_we;
        logic [2:0] dm_op;
        logic       reg_we;
        logic [1:0] wd_sel;
        logic [4:0] a3;
        logic [1:0] tnew;
    } mbndl_t;

    typedef struct packed {
        logic       reg_we;
        logic [1:0] wd_sel;
        logic [4:0] a3;
        logic [1:0] tnew;
    } wbndl_t;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic mbndl_t to_m(input bndl_t b);
        mbndl_t m;
        m.dm_we  = b.dm_we;
        m.dm_op  = b.dm_op;
        m.reg_we = b.reg_we;
        m.wd_sel = b.wd_sel;
        m.a3     = b.a3;
        m.tnew   = tnew_dec(b.tnew);
        return m;
    endfunction

    function automatic wbndl_t to_w(input mbndl_t b);
        wbndl_t w;
        w.reg_we = b.reg_we;
        w.wd_sel = b.wd_sel;
        w.a3     = b.a3;
        w.tnew   = tnew_dec(b.tnew);
        return w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_instr_decode.sv
// Decodes the D-stage instruction into the stage bundle, D controls and operand Tuse.
// Latency: purely combinational. Backpressure: none.
module instr_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RA_REG = 31
) (
    input  logic [31:0] instr,
    output bndl_t       bndl,
    output dctl_t       dctl,
    output logic [1:0]  tuse_rs,
    output logic [1:0]  tuse_rt
);
    localparam logic [4:0] RA = RA_REG[4:0];

    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       shamt_unused;

    assign op = instr[31:26];
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign rd = instr[15:11];
    assign fn = instr[5:0];
    assign shamt_unused = ^instr[10:6];

    always_comb begin
        bndl    = '0;
        dctl    = '0;
        tuse_rs = TUSE_ALU;
        tuse_rt = TUSE_ST;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADD, FN_SUB: begin
                        bndl.alu_op = (fn == FN_SUB) ? ALU_SUB : ALU_ADD;
                        bndl.rs     = rs;
                        bndl.rt     = rt;
                        bndl.a3     = rd;
                        bndl.tnew   = TNEW_ALU;
                        tuse_rt     = TUSE_ALU;
                    end
                    FN_JR, FN_JALR: begin
                        dctl.npc_op = NPC_JR;
                        bndl.rs     = rs;
                        tuse_rs     = TUSE_BR;
                        if (fn == FN_JALR) begin
                            bndl.a3     = rd;
                            bndl.wd_sel = WD_PC8;
                            bndl.tnew   = TNEW_LINK;
                        end
                    end
                    default: ;
                endcase
            end
            OP_ORI, OP_LUI: begin
                dctl.ext_op   = EXT_ZERO;
                bndl.alu_op   = (op == OP_ORI) ? ALU_OR : ALU_LUI;
                bndl.alub_sel = 1'b1;
                bndl.rs       = (op == OP_ORI) ? rs : 5'd0;
                bndl.a3       = rt;
                bndl.tnew     = TNEW_ALU;
            end
            OP_LW, OP_LB, OP_LH: begin
                dctl.ext_op   = EXT_SIGN;
                bndl.alub_sel = 1'b1;
                bndl.dm_op    = (op == OP_LB) ? DM_B : (op == OP_LH) ? DM_H : DM_W;
                bndl.rs       = rs;
                bndl.a3       = rt;
                bndl.wd_sel   = WD_MEM;
                bndl.tnew     = TNEW_LOAD;
            end
            OP_SW, OP_SB, OP_SH: begin
                dctl.ext_op   = EXT_SIGN;
                bndl.alub_sel = 1'b1;
                bndl.dm_we    = 1'b1;
                bndl.dm_op    = (op == OP_SB) ? DM_B : (op == OP_SH) ? DM_H : DM_W;
                bndl.rs       = rs;
                bndl.rt       = rt;
            end
            OP_BEQ: begin
                dctl.npc_op = NPC_BEQ;
                dctl.cmp_op = CMP_EQ;
                bndl.rs     = rs;
                bndl.rt     = rt;
                tuse_rs     = TUSE_BR;
                tuse_rt     = TUSE_BR;
            end
            OP_J: dctl.npc_op = NPC_J;
            OP_JAL: begin
                dctl.npc_op = NPC_J;
                bndl.a3     = RA;
                bndl.wd_sel = WD_PC8;
                bndl.tnew   = TNEW_LINK;
            end
            default: ;
        endcase
        // destination $0 means the instruction never writes
        bndl.reg_we = (bndl.a3 != 5'd0);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: decodes D, carries control bundles through E/M/W, resolves hazards.
// Latency: decode, stall and forward selects are combinational; stage controls one register per stage.
// Backpressure: stall freezes PC and F/D and bubbles E; M and W always advance.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned RA_REG = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic [2:0]  npc_op,
    output logic [1:0]  ext_op,
    output logic [2:0]  cmp_op,
    output logic [3:0]  alu_op,
    output logic        alub_sel,
    output logic        dm_we,
    output logic [2:0]  dm_op,
    output logic        reg_we,
    output logic [1:0]  reg_wd_sel,
    output logic [4:0]  a3_w,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e
);
    bndl_t      d_b, e_q;
    mbndl_t     m_q;
    wbndl_t     w_q;
    dctl_t      d_c;
    logic [1:0] tuse_rs, tuse_rt;

    instr_decode #(.RA_REG(RA_REG)) u_dec (
        .instr   (instr_d),
        .bndl    (d_b),
        .dctl    (d_c),
        .tuse_rs (tuse_rs),
        .tuse_rt (tuse_rt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= stall ? '0 : d_b;
            m_q <= to_m(e_q);
            w_q <= to_w(m_q);
        end
    end

    // Without forwarding any pending writer blocks; with it, only a producer that is late for its consumer
    function automatic logic pend(input logic [4:0] src, input logic [4:0] a3, input logic we,
                                  input logic [1:0] tnew, input logic [1:0] tuse);
        if (src == 5'd0 || src != a3) return 1'b0;
        return FWD_EN ? (tnew > tuse) : we;
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] src,
                                        input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                        input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                        input logic [4:0] w_a3, input logic [1:0] w_tnew);
        if (!FWD_EN || src == 5'd0) return FWD_GRF;
        if (src == e_a3 && e_tnew == 2'd0) return FWD_E;
        if (src == m_a3 && m_tnew == 2'd0) return FWD_M;
        if (src == w_a3 && w_tnew == 2'd0) return FWD_W;
        return FWD_GRF;
    endfunction

    always_comb begin
        stall = pend(d_b.rs, e_q.a3, e_q.reg_we, e_q.tnew, tuse_rs)
              | pend(d_b.rs, m_q.a3, m_q.reg_we, m_q.tnew, tuse_rs)
              | pend(d_b.rt, e_q.a3, e_q.reg_we, e_q.tnew, tuse_rt)
              | pend(d_b.rt, m_q.a3, m_q.reg_we, m_q.tnew, tuse_rt);
    end

    // Only PC+8 of a link instruction can be ready while still in E
    assign fwd_rs_d = fsel(d_b.rs, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);
    assign fwd_rt_d = fsel(d_b.rt, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);
    assign fwd_rs_e = fsel(e_q.rs, 5'd0, 2'd0, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);
    assign fwd_rt_e = fsel(e_q.rt, 5'd0, 2'd0, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);

    assign npc_op     = d_c.npc_op;
    assign ext_op     = d_c.ext_op;
    assign cmp_op     = d_c.cmp_op;
    assign alu_op     = e_q.alu_op;
    assign alub_sel   = e_q.alub_sel;
    assign dm_we      = m_q.dm_we;
    assign dm_op      = m_q.dm_op;
    assign reg_we     = w_q.reg_we;
    assign reg_wd_sel = w_q.wd_sel;
    assign a3_w       = w_q.a3;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Random instruction streams through a forwarding and a non-forwarding controller,
// checked against an instruction-level pipeline model.
module tb_pipe_ctrl;

    typedef enum int {I_NOP, I_BADFN, I_ADD, I_SUB, I_JR, I_JALR, I_ORI, I_LUI,
                      I_LW, I_LB, I_LH, I_SW, I_SB, I_SH, I_BEQ, I_J, I_JAL} mn_t;
    typedef struct { mn_t mn; int rs; int rt; int rd; } ins_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_d [2];
    logic        stall [2], alub_sel [2], dm_we [2], reg_we [2];
    logic [2:0]  npc_op [2], cmp_op [2], dm_op [2];
    logic [1:0]  ext_op [2], reg_wd_sel [2];
    logic [3:0]  alu_op [2];
    logic [4:0]  a3_w [2];
    logic [1:0]  fwd_rs_d [2], fwd_rt_d [2], fwd_rs_e [2], fwd_rt_e [2];

    pipe_ctrl #(.FWD_EN(1'b0), .RA_REG(31)) u_nofwd (
        .clk(clk), .reset(reset), .instr_d(instr_d[0]), .stall(stall[0]),
        .npc_op(npc_op[0]), .ext_op(ext_op[0]), .cmp_op(cmp_op[0]),
        .alu_op(alu_op[0]), .alub_sel(alub_sel[0]), .dm_we(dm_we[0]), .dm_op(dm_op[0]),
        .reg_we(reg_we[0]), .reg_wd_sel(reg_wd_sel[0]), .a3_w(a3_w[0]),
        .fwd_rs_d(fwd_rs_d[0]), .fwd_rt_d(fwd_rt_d[0]), .fwd_rs_e(fwd_rs_e[0]), .fwd_rt_e(fwd_rt_e[0])
    );

    pipe_ctrl #(.FWD_EN(1'b1), .RA_REG(31)) u_fwd (
        .clk(clk), .reset(reset), .instr_d(instr_d[1]), .stall(stall[1]),
        .npc_op(npc_op[1]), .ext_op(ext_op[1]), .cmp_op(cmp_op[1]),
        .alu_op(alu_op[1]), .alub_sel(alub_sel[1]), .dm_we(dm_we[1]), .dm_op(dm_op[1]),
        .reg_we(reg_we[1]), .reg_wd_sel(reg_wd_sel[1]), .a3_w(a3_w[1]),
        .fwd_rs_d(fwd_rs_d[1]), .fwd_rt_d(fwd_rt_d[1]), .fwd_rs_e(fwd_rs_e[1]), .fwd_rt_e(fwd_rt_e[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // model state: index 0 = no forwarding, 1 = forwarding; pipe age 0/1/2 = E/M/W
    ins_t pipe_m [2][3];
    ins_t cur [2];
    ins_t dq0 [$];
    ins_t dq1 [$];

    function automatic ins_t mk(input mn_t mn, input int rs, input int rt, input int rd);
        ins_t i;
        i.mn = mn; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic bit is_load(input mn_t m);  return m == I_LW || m == I_LB || m == I_LH; endfunction
    function automatic bit is_store(input mn_t m); return m == I_SW || m == I_SB || m == I_SH; endfunction

    function automatic int dst(input ins_t i);
        if (i.mn == I_ADD || i.mn == I_SUB || i.mn == I_JALR) return i.rd;
        if (i.mn == I_ORI || i.mn == I_LUI || is_load(i.mn))   return i.rt;
        if (i.mn == I_JAL) return 31;
        return 0;
    endfunction

    function automatic int srs(input ins_t i);
        if (i.mn inside {I_ADD, I_SUB, I_JR, I_JALR, I_ORI, I_BEQ} || is_load(i.mn) || is_store(i.mn)) return i.rs;
        return 0;
    endfunction

    function automatic int srt(input ins_t i);
        if (i.mn inside {I_ADD, I_SUB, I_BEQ} || is_store(i.mn)) return i.rt;
        return 0;
    endfunction

    function automatic int use_rs(input ins_t i); return (i.mn inside {I_BEQ, I_JR, I_JALR}) ? 0 : 1; endfunction
    function automatic int use_rt(input ins_t i); return (i.mn == I_BEQ) ? 0 : (i.mn inside {I_ADD, I_SUB}) ? 1 : 2; endfunction

    // cycles until the result exists, seen from pipeline age 0 (E), 1 (M), 2 (W)
    function automatic int ready_in(input ins_t i, input int age);
        int t;
        t = is_load(i.mn) ? 2 : (i.mn inside {I_ADD, I_SUB, I_ORI, I_LUI}) ? 1 : 0;
        return (t > age) ? t - age : 0;
    endfunction

    function automatic int blocks(input int k, input int s, input int tu);
        for (int age = 0; age < 2; age++)
            if (s != 0 && dst(pipe_m[k][age]) == s)
                if (k == 0 || ready_in(pipe_m[k][age], age) > tu) return 1;
        return 0;
    endfunction

    function automatic int exp_stall(input int k);
        return (blocks(k, srs(cur[k]), use_rs(cur[k])) != 0 || blocks(k, srt(cur[k]), use_rt(cur[k])) != 0) ? 1 : 0;
    endfunction

    function automatic int src_sel(input int k, input int s, input int first_age);
        if (k == 0 || s == 0) return 0;
        for (int age = first_age; age < 3; age++)
            if (dst(pipe_m[k][age]) == s && ready_in(pipe_m[k][age], age) == 0)
                return (age == 0) ? 3 : (age == 1) ? 1 : 2;
        return 0;
    endfunction

    function automatic logic [31:0] enc(input ins_t i);
        logic [31:0] w;
        w = $urandom;
        case (i.mn)
            I_NOP:   w[31:26] = 6'h3f;
            I_BADFN: begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
            I_ADD, I_SUB, I_JR, I_JALR: begin
                w[31:26] = 6'h00;
                w[25:21] = 5'(i.rs); w[20:16] = 5'(i.rt); w[15:11] = 5'(i.rd);
                w[5:0] = (i.mn == I_ADD) ? 6'h20 : (i.mn == I_SUB) ? 6'h22 : (i.mn == I_JR) ? 6'h08 : 6'h09;
            end
            I_J:   w[31:26] = 6'h02;
            I_JAL: w[31:26] = 6'h03;
            default: begin
                case (i.mn)
                    I_ORI: w[31:26] = 6'h0d;
                    I_LUI: w[31:26] = 6'h0f;
                    I_LW:  w[31:26] = 6'h23;
                    I_LB:  w[31:26] = 6'h20;
                    I_LH:  w[31:26] = 6'h21;
                    I_SW:  w[31:26] = 6'h2b;
                    I_SB:  w[31:26] = 6'h28;
                    I_SH:  w[31:26] = 6'h29;
                    default: w[31:26] = 6'h04;
                endcase
                w[25:21] = 5'(i.rs); w[20:16] = 5'(i.rt);
            end
        endcase
        return w;
    endfunction

    function automatic int rreg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 31 : r;
    endfunction

    function automatic ins_t nxt(input int k);
        if (k == 0 && dq0.size() > 0) return dq0.pop_front();
        if (k == 1 && dq1.size() > 0) return dq1.pop_front();
        return mk(mn_t'($urandom_range(0, 16)), rreg(), rreg(), rreg());
    endfunction

    task automatic push_both(input ins_t i);
        dq0.push_back(i);
        dq1.push_back(i);
    endtask

    task automatic check_all(input int k);
        ins_t c, e, m, w;
        c = cur[k]; e = pipe_m[k][0]; m = pipe_m[k][1]; w = pipe_m[k][2];
        check($sformatf("k%0d_stall", k), 32'(stall[k]), exp_stall(k));
        check($sformatf("k%0d_npc_op", k), 32'(npc_op[k]),
              (c.mn == I_BEQ) ? 1 : (c.mn inside {I_JR, I_JALR}) ? 2 : (c.mn inside {I_J, I_JAL}) ? 3 : 0);
        check($sformatf("k%0d_ext_op", k), 32'(ext_op[k]), (is_load(c.mn) || is_store(c.mn)) ? 1 : 0);
        check($sformatf("k%0d_cmp_op", k), 32'(cmp_op[k]), 0);
        check($sformatf("k%0d_alu_op", k), 32'(alu_op[k]),
              (e.mn == I_SUB) ? 1 : (e.mn == I_ORI) ? 2 : (e.mn == I_LUI) ? 3 : 0);
        check($sformatf("k%0d_alub_sel", k), 32'(alub_sel[k]),
              (e.mn inside {I_ORI, I_LUI} || is_load(e.mn) || is_store(e.mn)) ? 1 : 0);
        check($sformatf("k%0d_dm_we", k), 32'(dm_we[k]), is_store(m.mn) ? 1 : 0);
        check($sformatf("k%0d_dm_op", k), 32'(dm_op[k]),
              (m.mn inside {I_LB, I_SB}) ? 1 : (m.mn inside {I_LH, I_SH}) ? 2 : 0);
        check($sformatf("k%0d_reg_we", k), 32'(reg_we[k]), (dst(w) != 0) ? 1 : 0);
        check($sformatf("k%0d_reg_wd_sel", k), 32'(reg_wd_sel[k]),
              is_load(w.mn) ? 1 : (w.mn inside {I_JAL, I_JALR}) ? 2 : 0);
        check($sformatf("k%0d_a3_w", k), 32'(a3_w[k]), dst(w));
        check($sformatf("k%0d_fwd_rs_d", k), 32'(fwd_rs_d[k]), src_sel(k, srs(c), 0));
        check($sformatf("k%0d_fwd_rt_d", k), 32'(fwd_rt_d[k]), src_sel(k, srt(c), 0));
        check($sformatf("k%0d_fwd_rs_e", k), 32'(fwd_rs_e[k]), src_sel(k, srs(e), 1));
        check($sformatf("k%0d_fwd_rt_e", k), 32'(fwd_rt_e[k]), src_sel(k, srt(e), 1));
    endtask

    task automatic check_reset_zero(input int k);
        check($sformatf("k%0d_rst_stall", k), 32'(stall[k]), 0);
        check($sformatf("k%0d_rst_stage", k),
              {17'd0, alu_op[k], alub_sel[k], dm_we[k], dm_op[k], reg_we[k], reg_wd_sel[k], a3_w[k]}, 0);
        check($sformatf("k%0d_rst_fwd", k), {24'd0, fwd_rs_d[k], fwd_rt_d[k], fwd_rs_e[k], fwd_rt_e[k]}, 0);
    endtask

    task automatic push_lw_use();
        push_both(mk(I_LW, 0, 1, 0));
        push_both(mk(I_ADD, 1, 1, 2));
    endtask

    int est [2];
    int lw_stalls [2];
    int resets_done = 0;
    bit armed = 1'b0;

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 3; a++) pipe_m[k][a] = mk(I_NOP, 0, 0, 0);
            cur[k] = mk(I_NOP, 0, 0, 0);
            instr_d[k] = enc(cur[k]);
            lw_stalls[k] = 0;
        end
        push_lw_use();
        repeat (3) push_both(mk(I_NOP, 0, 0, 0));
        push_both(mk(I_ADD, 1, 2, 3));
        push_both(mk(I_BEQ, 3, 0, 0));
        repeat (3) push_both(mk(I_NOP, 0, 0, 0));
        push_both(mk(I_JAL, 0, 0, 0));
        push_both(mk(I_JR, 31, 0, 0));
        repeat (3) push_both(mk(I_NOP, 0, 0, 0));
        push_both(mk(I_ORI, 0, 0, 0));
        push_both(mk(I_ADD, 0, 0, 4));
        repeat (3) push_both(mk(I_NOP, 0, 0, 0));

        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check_reset_zero(k);
                check_all(k);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cur[k] = nxt(k);
            instr_d[k] = enc(cur[k]);
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check_all(k);
                est[k] = exp_stall(k);
                if (cyc < 6) lw_stalls[k] += int'(stall[k]);
            end
            if (cyc == 300 || cyc == 1200 || cyc == 2100) begin
                push_lw_use();
                armed = 1'b1;
            end
            if (armed && est[1] != 0) begin
                armed = 1'b0;
                resets_done++;
                #1 reset = 1'b1;
                #1;
                for (int k = 0; k < 2; k++) begin
                    check_reset_zero(k);
                    for (int a = 0; a < 3; a++) pipe_m[k][a] = mk(I_NOP, 0, 0, 0);
                end
                @(negedge clk);
                for (int k = 0; k < 2; k++) check_all(k);
                @(posedge clk);
                #1 reset = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    cur[k] = nxt(k);
                    instr_d[k] = enc(cur[k]);
                end
                continue;
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                pipe_m[k][2] = pipe_m[k][1];
                pipe_m[k][1] = pipe_m[k][0];
                pipe_m[k][0] = (est[k] != 0) ? mk(I_NOP, 0, 0, 0) : cur[k];
                if (est[k] == 0) cur[k] = nxt(k);
            end
            #1;
            for (int k = 0; k < 2; k++) instr_d[k] = enc(cur[k]);
        end

        check("lw_use_stall_cycles_fwd", lw_stalls[1], 1);
        check("lw_use_stall_cycles_nofwd", lw_stalls[0], 2);
        check("mid_stall_resets", resets_done, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
